// File: rtl/tdm_pkg.sv
// Shared definitions for the four-slot TDM link.
// Used by both the multiplexer side and the tdm_demux4 receiver.
package tdm_pkg;

  // Number of time slots (channels) in one frame.
  localparam int NUM_SLOTS = 4;

  // Receiver alignment state.
  typedef enum logic {
    HUNT    = 1'b0,
    COLLECT = 1'b1
  } tdm_state_e;

endpackage

// File: rtl/tdm_gap_timer.sv
// Idle-gap timer for the TDM receiver.
// Counts cycles while 'en' is high and reports a timeout on the cycle
// in which the count would pass GAP_MAX.
// Ports:
//   clk     : rising-edge clock
//   rst_n   : asynchronous active-low reset
//   clr     : synchronous clear of the count
//   en      : count this cycle (an idle cycle inside a partial frame)
//   expired : combinational timeout, valid in the cycle that would overflow
module tdm_gap_timer #(
  parameter int GAP_MAX = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(GAP_MAX + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // An idle cycle arriving when the count already sits at GAP_MAX is the
  // one that would exceed the limit.
  assign expired = en && (cnt_q == CW'(GAP_MAX));

  // The count restarts after a timeout so the next frame starts clean;
  // otherwise it saturates at GAP_MAX.
  always_comb begin
    cnt_d = cnt_q;
    if (clr || expired) begin
      cnt_d = '0;
    end else if (en && (cnt_q != CW'(GAP_MAX))) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/tdm_demux4.sv
// Four-slot time-division demultiplexer.
// Aligns to frame_sync, stages one sample per slot and publishes a whole
// frame at once on ch_data with a one-cycle ch_valid strobe.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   din        : sample for the current slot
//   din_valid  : din carries a sample this cycle
//   frame_sync : marks a valid sample as slot 0
//   ch_data    : last complete frame, channel k at [k*WIDTH +: WIDTH]
//   ch_valid   : pulses when ch_data has just been updated
//   slot       : index of the next slot expected
//   locked     : high while aligned (COLLECT)
//   frame_err  : pulses when a partial frame is discarded
module tdm_demux4
  import tdm_pkg::*;
#(
  parameter int WIDTH   = 1,
  parameter int GAP_MAX = 15
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [WIDTH-1:0]           din,
  input  logic                       din_valid,
  input  logic                       frame_sync,
  output logic [NUM_SLOTS*WIDTH-1:0] ch_data,
  output logic                       ch_valid,
  output logic [1:0]                 slot,
  output logic                       locked,
  output logic                       frame_err
);

  tdm_state_e                 state_q, state_d;
  logic [1:0]                 slot_q, slot_d;
  // Slot 3 is never staged: it goes straight into ch_data with slots 0..2.
  logic [WIDTH-1:0]           stage_q [3];
  logic [WIDTH-1:0]           stage_d [3];
  logic [NUM_SLOTS*WIDTH-1:0] ch_data_q, ch_data_d;
  logic                       ch_valid_q, ch_valid_d;
  logic                       frame_err_q, frame_err_d;
  logic                       gap_en;
  logic                       gap_expired;

  // Idle cycles only matter while a frame is partly collected.
  assign gap_en = (state_q == COLLECT) && (slot_q != 2'd0) && !din_valid;

  tdm_gap_timer #(
    .GAP_MAX (GAP_MAX)
  ) u_gap_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (!gap_en),
    .en      (gap_en),
    .expired (gap_expired)
  );

  always_comb begin
    state_d     = state_q;
    slot_d      = slot_q;
    stage_d     = stage_q;
    ch_data_d   = ch_data_q;
    ch_valid_d  = 1'b0;
    frame_err_d = 1'b0;

    case (state_q)
      HUNT: begin
        if (din_valid && frame_sync) begin
          stage_d[0] = din;
          slot_d     = 2'd1;
          state_d    = COLLECT;
        end
      end

      COLLECT: begin
        if (din_valid) begin
          if (frame_sync) begin
            // A sync anywhere but slot 0 abandons the partial frame and
            // realigns on this sample.
            frame_err_d = (slot_q != 2'd0);
            stage_d[0]  = din;
            slot_d      = 2'd1;
          end else if (slot_q == 2'd0) begin
            // Sync missing where a frame should start: alignment lost.
            frame_err_d = 1'b1;
            state_d     = HUNT;
          end else begin
            slot_d = slot_q + 2'd1;
            case (slot_q)
              2'd1:    stage_d[1] = din;
              2'd2:    stage_d[2] = din;
              default: begin
                ch_data_d  = {din, stage_q[2], stage_q[1], stage_q[0]};
                ch_valid_d = 1'b1;
              end
            endcase
          end
        end else if (gap_expired) begin
          frame_err_d = 1'b1;
          state_d     = HUNT;
          slot_d      = 2'd0;
        end
      end

      default: begin
        state_d = HUNT;
        slot_d  = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= HUNT;
      slot_q      <= 2'd0;
      for (int i = 0; i < 3; i++) begin
        stage_q[i] <= '0;
      end
      ch_data_q   <= '0;
      ch_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      stage_q     <= stage_d;
      ch_data_q   <= ch_data_d;
      ch_valid_q  <= ch_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign ch_data   = ch_data_q;
  assign ch_valid  = ch_valid_q;
  assign slot      = slot_q;
  assign locked    = (state_q == COLLECT);
  assign frame_err = frame_err_q;

endmodule
